param_stack: RTL and testbench

PARAM_STACK -- requirements
Module: param_stack

---
 rtl/param_stack.sv | 146 ++++++++++++++
 tb/tb_param_stack.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/param_stack.sv
// Parameterised LIFO stack with registered pop/peek output, occupancy count,
// and sticky overflow/underflow flags.
module param_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             data_in,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         tos,
  input  logic                         clr_err,
  output logic [WIDTH-1:0]             data_out,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  // Saturating counter steps; the counter can never wrap in either direction.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    if (c >= CNT_MAX) return CNT_MAX;
    return c + CW'(1);
  endfunction

  function automatic logic [CW-1:0] sat_dec(input logic [CW-1:0] c);
    if (c == '0) return '0;
    return c - CW'(1);
  endfunction

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    wr_idx;
  logic [WIDTH-1:0] top_word;

  logic             push_only;
  logic             pop_only;
  logic             swap;
  logic             bypass;
  logic             peek;
  logic             wr_en;
  logic             ld_top;
  logic             ld_in;
  logic             ovf_evt;
  logic             unf_evt;
  logic [CW-1:0]    count_nxt;

  assign empty = (count == '0);
  assign full  = (count == CNT_MAX);

  // Top lives at count-1; a plain push lands at count, a swap overwrites the top.
  assign top_idx  = AW'(count - CW'(1));
  assign top_word = mem[top_idx];

  always_comb begin
    push_only = 1'b0;
    pop_only  = 1'b0;
    swap      = 1'b0;
    bypass    = 1'b0;
    peek      = 1'b0;
    wr_en     = 1'b0;
    wr_idx    = AW'(count);
    ld_top    = 1'b0;
    ld_in     = 1'b0;
    ovf_evt   = 1'b0;
    unf_evt   = 1'b0;
    count_nxt = count;

    push_only = push & ~pop;
    pop_only  = pop & ~push;
    swap      = push & pop & ~empty;
    bypass    = push & pop & empty;
    peek      = tos & ~pop & ~empty;

    if (push_only) begin
      if (full) begin
        ovf_evt = 1'b1;
      end else begin
        wr_en     = 1'b1;
        count_nxt = sat_inc(count);
      end
    end

    if (pop_only) begin
      if (empty) begin
        unf_evt = 1'b1;
      end else begin
        ld_top    = 1'b1;
        count_nxt = sat_dec(count);
      end
    end

    if (swap) begin
      wr_en  = 1'b1;
      wr_idx = top_idx;
      ld_top = 1'b1;
    end

    if (bypass) begin
      ld_in = 1'b1;
    end

    // Peek reads the memory before any same-edge push, so it returns the old top.
    if (peek) begin
      ld_top = 1'b1;
    end

    // Writes are dropped while reset is held so a discarded push leaves no trace.
    wr_en = wr_en & rst;
  end

  // Storage: no reset, contents are only meaningful below count.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= data_in;
    end
  end

  // Control and output register stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count     <= '0;
      data_out  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count <= count_nxt;
      if (ld_in) begin
        data_out <= data_in;
      end else if (ld_top) begin
        data_out <= top_word;
      end
      // A new error in the same cycle as clr_err wins.
      overflow  <= ovf_evt | (overflow & ~clr_err);
      underflow <= unf_evt | (underflow & ~clr_err);
    end
  end

endmodule

// File: tb/tb_param_stack.sv
// Directed bench for param_stack (WIDTH=8, DEPTH=4): queue-based reference model
// checked every cycle, plus hand-computed expectations for the key scenarios.
module tb_param_stack;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic             push = 1'b0;
  logic             pop = 1'b0;
  logic             tos = 1'b0;
  logic             clr_err = 1'b0;
  logic [WIDTH-1:0] data_out;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  param_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .push(push), .pop(pop), .tos(tos),
    .clr_err(clr_err), .data_out(data_out), .count(count), .empty(empty),
    .full(full), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Reference model: a queue whose back is the top of stack.
  logic [7:0] mq[$];
  logic [7:0] m_dout = 8'h00;
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit p, input bit q, input bit t, input bit c,
                            input logic [7:0] d);
    bit oe = 1'b0;
    bit ue = 1'b0;
    if (q) begin
      if (mq.size() > 0) begin
        m_dout = mq.pop_back();
        if (p) mq.push_back(d);
      end else if (p) begin
        m_dout = d;
      end else begin
        ue = 1'b1;
      end
    end else begin
      if (t && mq.size() > 0) m_dout = mq[$];
      if (p) begin
        if (mq.size() < DEPTH) mq.push_back(d);
        else oe = 1'b1;
      end
    end
    m_ovf = oe | (m_ovf & ~c);
    m_unf = ue | (m_unf & ~c);
  endtask

  task automatic cyc(input bit p, input bit q, input bit t, input bit c,
                     input logic [7:0] d);
    push = p; pop = q; tos = t; clr_err = c; data_in = d;
    @(posedge clk);
    model_step(p, q, t, c, d);
    @(negedge clk);
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_data_out",  32'(data_out),  32'(m_dout));
      chk("m_count",     32'(count),     32'(mq.size()));
      chk("m_empty",     32'(empty),     32'(mq.size() == 0));
      chk("m_full",      32'(full),      32'(mq.size() == DEPTH));
      chk("m_overflow",  32'(overflow),  32'(m_ovf));
      chk("m_underflow", 32'(underflow), 32'(m_unf));
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_count", 32'(count), 0);
    chk("rst_dout",  32'(data_out), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full",  32'(full), 0);
    chk("rst_flags", {30'd0, overflow, underflow}, 0);
    rst = 1'b1;
    chk_en = 1'b1;

    // Push then peek.
    cyc(1, 0, 0, 0, 8'h0C);
    cyc(0, 0, 1, 0, 8'h00);
    chk("tos_dout",  32'(data_out), 32'h0C);
    chk("tos_count", 32'(count), 1);
    cyc(0, 1, 0, 0, 8'h00);
    chk("pop_0c", 32'(data_out), 32'h0C);

    // Fill, overflow, drain.
    cyc(1, 0, 0, 0, 8'h11);
    cyc(1, 0, 0, 0, 8'h22);
    cyc(1, 0, 0, 0, 8'h33);
    cyc(1, 0, 0, 0, 8'h44);
    cyc(1, 0, 0, 0, 8'h55);
    chk("ovf_full",  32'(full), 1);
    chk("ovf_count", 32'(count), 4);
    chk("ovf_flag",  32'(overflow), 1);
    cyc(0, 1, 0, 0, 8'h00); chk("pop1", 32'(data_out), 32'h44);
    cyc(0, 1, 0, 0, 8'h00); chk("pop2", 32'(data_out), 32'h33);
    cyc(0, 1, 0, 0, 8'h00); chk("pop3", 32'(data_out), 32'h22);
    cyc(0, 1, 0, 0, 8'h00); chk("pop4", 32'(data_out), 32'h11);
    chk("drain_empty", 32'(empty), 1);

    // Underflow and clear semantics.
    cyc(0, 1, 0, 0, 8'h00);
    chk("unf_flag", 32'(underflow), 1);
    chk("unf_dout", 32'(data_out), 32'h11);
    cyc(0, 0, 0, 1, 8'h00);
    chk("clr_unf", 32'(underflow), 0);
    chk("clr_ovf", 32'(overflow), 0);
    cyc(0, 1, 0, 1, 8'h00);
    chk("clr_vs_err", 32'(underflow), 1);
    cyc(0, 0, 0, 1, 8'h00);

    // Push+pop replaces the top.
    cyc(1, 0, 0, 0, 8'h01);
    cyc(1, 0, 0, 0, 8'h02);
    cyc(1, 1, 0, 0, 8'hAA);
    chk("swap_dout",  32'(data_out), 32'h02);
    chk("swap_count", 32'(count), 2);
    cyc(0, 1, 0, 0, 8'h00);
    chk("swap_pop", 32'(data_out), 32'hAA);
    cyc(0, 1, 0, 0, 8'h00);
    chk("swap_pop2", 32'(data_out), 32'h01);

    // Bypass on empty, replace at full.
    cyc(1, 1, 0, 0, 8'h5A);
    chk("byp_dout",  32'(data_out), 32'h5A);
    chk("byp_count", 32'(count), 0);
    chk("byp_flags", {30'd0, overflow, underflow}, 0);
    cyc(1, 0, 0, 0, 8'hA1);
    cyc(1, 0, 0, 0, 8'hA2);
    cyc(1, 0, 0, 0, 8'hA3);
    cyc(1, 0, 0, 0, 8'hA4);
    cyc(1, 1, 0, 0, 8'hB0);
    chk("full_swap_count", 32'(count), 4);
    chk("full_swap_ovf",   32'(overflow), 0);
    chk("full_swap_dout",  32'(data_out), 32'hA4);

    // Peek alongside push returns the pre-push top; peek with pop yields to pop.
    cyc(1, 0, 1, 0, 8'hC0);
    chk("tos_push_full", 32'(data_out), 32'hB0);
    chk("tos_push_ovf",  32'(overflow), 1);
    cyc(0, 1, 1, 1, 8'h00);
    chk("pop_over_tos", 32'(data_out), 32'hB0);
    cyc(1, 0, 1, 0, 8'hC3);
    chk("tos_prepush", 32'(data_out), 32'hA3);
    chk("tos_prepush_cnt", 32'(count), 4);

    // Drain, refill three, then assert reset mid-cycle.
    repeat (4) cyc(0, 1, 0, 0, 8'h00);
    cyc(0, 0, 1, 0, 8'h00);
    chk("tos_empty_hold", 32'(data_out), 32'hA1);
    cyc(1, 0, 0, 0, 8'hD1);
    cyc(1, 0, 0, 0, 8'hD2);
    cyc(1, 0, 0, 0, 8'hD3);
    push = 1'b1; pop = 1'b0; tos = 1'b0; clr_err = 1'b0; data_in = 8'hE0;
    #2;
    rst = 1'b0;
    mq.delete(); m_dout = 8'h00; m_ovf = 1'b0; m_unf = 1'b0;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_dout",  32'(data_out), 0);
    chk("arst_empty", 32'(empty), 1);
    chk("arst_full",  32'(full), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    push = 1'b0;
    cyc(0, 0, 0, 0, 8'h00);
    chk("push_lost", 32'(count), 0);
    cyc(1, 0, 0, 0, 8'h77);
    cyc(0, 1, 0, 0, 8'h00);
    chk("post_rst_pop", 32'(data_out), 32'h77);
    cyc(0, 0, 0, 0, 8'h00);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
